// File: rtl/lsu_misalign_split.sv
// Splits byte/half/word core accesses at any alignment into one or two
// word-aligned downstream accesses and merges/extends load results.
`timescale 1ns/1ps
module lsu_misalign_split #(
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          core_req_i,
  output logic          core_gnt_o,
  input  logic          core_we_i,
  input  logic [1:0]    core_size_i,
  input  logic          core_sext_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [31:0]   core_wdata_i,
  output logic          core_rvalid_o,
  output logic [31:0]   core_rdata_o,
  output logic          core_err_o,
  output logic          data_req_o,
  input  logic          data_gnt_i,
  input  logic          data_rvalid_i,
  output logic          data_we_o,
  output logic [AW-1:0] data_addr_o,
  output logic [3:0]    data_be_o,
  output logic [31:0]   data_wdata_o,
  input  logic [31:0]   data_rdata_i
);

  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2} state_e;

  state_e      state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic        split_q;
  logic [3:0]  be2_q;
  logic [31:0] wdata2_q;
  logic [31:0] lo_q;

  logic [7:0]  base_mask;
  logic [7:0]  req_mask;
  logic [63:0] req_wide;
  logic [63:0] req_lanes;

  // Byte-lane mask and shifted store data across the two candidate words.
  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    base_mask = 8'h0F;
    case (core_size_i)
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
    req_mask = base_mask << core_addr_i[1:0];
    req_wide = {32'b0, core_wdata_i} << {core_addr_i[1:0], 3'b000};
    for (int i = 0; i < 8; i++) begin
      req_lanes[8*i +: 8] = req_wide[8*i +: 8] & {8{req_mask[i]}};
    end
  end

  assign core_gnt_o = core_req_i && (state == IDLE);

  function automatic logic [31:0] form_result(input logic [63:0] rd,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        sext);
    logic [31:0] sh;
    sh = rd[8*off +: 32];
    case (size)
      2'd0:    return {{24{sext & sh[7]}}, sh[7:0]};
      2'd1:    return {{16{sext & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      off_q         <= '0;
      size_q        <= '0;
      sext_q        <= 1'b0;
      split_q       <= 1'b0;
      be2_q         <= '0;
      wdata2_q      <= '0;
      lo_q          <= '0;
      core_rvalid_o <= 1'b0;
      core_err_o    <= 1'b0;
      core_rdata_o  <= '0;
      data_req_o    <= 1'b0;
      data_we_o     <= 1'b0;
      data_addr_o   <= '0;
      data_be_o     <= '0;
      data_wdata_o  <= '0;
    end else begin
      core_rvalid_o <= 1'b0;
      core_err_o    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (core_req_i) begin
            off_q     <= core_addr_i[1:0];
            size_q    <= core_size_i;
            sext_q    <= core_sext_i;
            data_we_o <= core_we_i;
            if (core_size_i == 2'd3) begin
              core_rvalid_o <= 1'b1;
              core_err_o    <= 1'b1;
              core_rdata_o  <= '0;
            end else begin
              state        <= REQ1;
              data_req_o   <= 1'b1;
              data_addr_o  <= {core_addr_i[AW-1:2], 2'b00};
              data_be_o    <= req_mask[3:0];
              data_wdata_o <= req_lanes[31:0];
              be2_q        <= req_mask[7:4];
              wdata2_q     <= req_lanes[63:32];
              split_q      <= |req_mask[7:4];
            end
          end
        end
        REQ1: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state      <= WAIT1;
          end
        end
        WAIT1: begin
          if (data_rvalid_i) begin
            lo_q <= data_rdata_i;
            if (split_q) begin
              // Second word; address arithmetic wraps naturally at 2^AW.
              state        <= REQ2;
              data_req_o   <= 1'b1;
              data_addr_o  <= data_addr_o + AW'(4);
              data_be_o    <= be2_q;
              data_wdata_o <= wdata2_q;
            end else begin
              state         <= IDLE;
              core_rvalid_o <= 1'b1;
              core_rdata_o  <= data_we_o ? 32'b0 :
                               form_result({32'b0, data_rdata_i}, off_q, size_q, sext_q);
            end
          end
        end
        REQ2: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state      <= WAIT2;
          end
        end
        WAIT2: begin
          if (data_rvalid_i) begin
            state         <= IDLE;
            core_rvalid_o <= 1'b1;
            core_rdata_o  <= data_we_o ? 32'b0 :
                             form_result({data_rdata_i, lo_q}, off_q, size_q, sext_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_misalign_split.sv
// Scoreboard bench: a byte-level reference memory predicts downstream accesses
// and core responses; a word-level responder plays the memory side.
`timescale 1ns/1ps
module tb_lsu_misalign_split;
  localparam int AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          core_req_i = 1'b0;
  logic          core_gnt_o;
  logic          core_we_i = 1'b0;
  logic [1:0]    core_size_i = '0;
  logic          core_sext_i = 1'b0;
  logic [AW-1:0] core_addr_i = '0;
  logic [31:0]   core_wdata_i = '0;
  logic          core_rvalid_o;
  logic [31:0]   core_rdata_o;
  logic          core_err_o;
  logic          data_req_o;
  logic          data_gnt_i = 1'b0;
  logic          data_rvalid_i = 1'b0;
  logic          data_we_o;
  logic [AW-1:0] data_addr_o;
  logic [3:0]    data_be_o;
  logic [31:0]   data_wdata_o;
  logic [31:0]   data_rdata_i = '0;

  lsu_misalign_split #(.AW(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_we_i(core_we_i),
    .core_size_i(core_size_i), .core_sext_i(core_sext_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_rvalid_o(core_rvalid_o),
    .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_we_o(data_we_o), .data_addr_o(data_addr_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  acc_t        exp_acc[$];
  resp_t       exp_resp[$];
  logic [7:0]  refmem [logic [31:0]];
  logic [31:0] dmem   [logic [31:0]];

  int n_checks = 0;
  int n_fail   = 0;
  bit zero_wait   = 1'b0;
  bit force_stall = 1'b0;
  bit resp_block  = 1'b0;

  // Responder state
  bit          in_acc = 1'b0;
  bit          resp_pend = 1'b0;
  int          stall_left = 0;
  int          resp_delay = 0;
  logic [31:0] resp_data = '0;
  acc_t        snap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] b);
    logic [31:0] w;
    if (refmem.exists(b)) return refmem[b];
    w = init_word({b[31:2], 2'b00});
    return w[8*b[1:0] +: 8];
  endfunction

  function automatic logic [31:0] dmem_read(input logic [31:0] w);
    if (dmem.exists(w)) return dmem[w];
    return init_word(w);
  endfunction

  task automatic preload(input logic [31:0] w, input logic [31:0] val);
    dmem[w] = val;
    for (int i = 0; i < 4; i++) refmem[w + i] = val[8*i +: 8];
  endtask

  // Reference: walk the request byte by byte, grouping bytes into words.
  task automatic model(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata);
    resp_t       r;
    acc_t        a;
    bit          have;
    int          n;
    logic [31:0] b;
    logic [31:0] val;
    if (size == 2'd3) begin
      r.err   = 1'b1;
      r.rdata = '0;
      exp_resp.push_back(r);
      return;
    end
    n    = 1 << size;
    val  = '0;
    have = 1'b0;
    a    = '0;
    for (int i = 0; i < n; i++) begin
      b = addr + i;
      if (!have || a.addr != {b[31:2], 2'b00}) begin
        if (have) exp_acc.push_back(a);
        a      = '0;
        a.addr = {b[31:2], 2'b00};
        a.we   = we;
        have   = 1'b1;
      end
      a.be[b[1:0]] = 1'b1;
      if (we) begin
        a.wdata[8*b[1:0] +: 8] = wdata[8*i +: 8];
        refmem[b] = wdata[8*i +: 8];
      end else begin
        val[8*i +: 8] = ref_byte(b);
      end
    end
    exp_acc.push_back(a);
    if (sext && n == 1) val = {{24{val[7]}}, val[7:0]};
    if (sext && n == 2) val = {{16{val[15]}}, val[15:0]};
    r.err   = 1'b0;
    r.rdata = we ? 32'b0 : val;
    exp_resp.push_back(r);
  endtask

  // Memory-side responder: grants with optional stalls, answers with latency.
  initial begin
    logic [31:0] w;
    acc_t a;
    forever begin
      @(negedge clk_i);
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      if (!rst_ni) begin
        in_acc    = 1'b0;
        resp_pend = 1'b0;
      end else begin
        if (resp_pend) begin
          if (!resp_block) begin
            if (resp_delay == 0) begin
              data_rvalid_i = 1'b1;
              data_rdata_i  = resp_data;
              resp_pend     = 1'b0;
            end else begin
              resp_delay--;
            end
          end
        end else if (!zero_wait && $urandom_range(0, 7) == 0) begin
          data_rvalid_i = 1'b1;
          data_rdata_i  = $urandom;
        end
        if (data_req_o) begin
          if (!in_acc) begin
            in_acc = 1'b1;
            snap   = {data_addr_o, data_be_o, data_we_o, data_wdata_o};
            stall_left = force_stall ? 3 : (zero_wait ? 0 : $urandom_range(0, 2));
            if (exp_acc.size() == 0) fail_now("unexpected_data_req");
          end else begin
            check("stable_addr", data_addr_o, snap.addr);
            check("stable_be", {28'b0, data_be_o}, {28'b0, snap.be});
            check("stable_wdata", data_wdata_o, snap.wdata);
          end
          if (stall_left == 0) begin
            data_gnt_i = 1'b1;
            in_acc     = 1'b0;
            if (exp_acc.size() != 0) begin
              a = exp_acc.pop_front();
              check("acc_addr", data_addr_o, a.addr);
              check("acc_be", {28'b0, data_be_o}, {28'b0, a.be});
              check("acc_we", {31'b0, data_we_o}, {31'b0, a.we});
              if (a.we) check("acc_wdata", data_wdata_o, a.wdata);
            end
            w = dmem_read(data_addr_o);
            if (data_we_o) begin
              for (int l = 0; l < 4; l++)
                if (data_be_o[l]) w[8*l +: 8] = data_wdata_o[8*l +: 8];
              dmem[data_addr_o] = w;
            end
            resp_data  = w;
            resp_pend  = 1'b1;
            resp_delay = zero_wait ? 0 : $urandom_range(0, 2);
          end else begin
            stall_left--;
          end
        end
      end
    end
  end

  // Core-side monitor
  initial begin
    resp_t r;
    forever begin
      @(negedge clk_i);
      if (rst_ni && core_rvalid_o) begin
        if (exp_resp.size() == 0) begin
          fail_now("unexpected_core_rvalid");
        end else begin
          r = exp_resp.pop_front();
          check("core_err", {31'b0, core_err_o}, {31'b0, r.err});
          check("core_rdata", core_rdata_o, r.rdata);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    model(we, size, sext, addr, wdata);
    @(negedge clk_i);
    core_req_i   = 1'b1;
    core_we_i    = we;
    core_size_i  = size;
    core_sext_i  = sext;
    core_addr_i  = addr;
    core_wdata_i = wdata;
    #1;
    guard = 0;
    while (!core_gnt_o && guard < 500) begin
      @(negedge clk_i);
      #1;
      guard++;
    end
    if (!core_gnt_o) fail_now("core_gnt_timeout");
    @(posedge clk_i);
    #1;
    core_req_i = 1'b0;
  endtask

  task automatic wait_rvalid(output int lat);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!core_rvalid_o && lat < 200);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int guard;
    logic [1:0]  sz;
    logic [31:0] ad;

    repeat (3) @(negedge clk_i);
    check("rst_data_req", {31'b0, data_req_o}, 32'd0);
    check("rst_core_rvalid", {31'b0, core_rvalid_o}, 32'd0);
    check("rst_core_err", {31'b0, core_err_o}, 32'd0);
    check("rst_core_rdata", core_rdata_o, 32'd0);
    check("rst_data_addr", data_addr_o, 32'd0);
    check("rst_data_be", {28'b0, data_be_o}, 32'd0);
    check("rst_data_wdata", data_wdata_o, 32'd0);
    check("rst_data_we", {31'b0, data_we_o}, 32'd0);
    rst_ni = 1'b1;

    // Directed cases with a zero-wait memory
    zero_wait = 1'b1;
    preload(32'h100, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    wait_rvalid(lat);
    check("lat_aligned", lat, 32'd3);

    issue(1'b1, 2'd2, 1'b0, 32'h103, 32'hAABB_CCDD);
    wait_rvalid(lat);
    check("lat_split", lat, 32'd5);

    preload(32'h200, 32'h1122_3344);
    preload(32'h204, 32'h5566_77F8);
    issue(1'b0, 2'd1, 1'b1, 32'h203, 32'h0);
    wait_rvalid(lat);
    issue(1'b0, 2'd1, 1'b0, 32'h203, 32'h0);
    wait_rvalid(lat);

    preload(32'h300, 32'h00AB_0000);
    issue(1'b0, 2'd0, 1'b0, 32'h302, 32'hFFFF_FFFF);
    wait_rvalid(lat);

    issue(1'b0, 2'd2, 1'b1, 32'hFFFF_FFFE, 32'h0);
    wait_rvalid(lat);

    issue(1'b0, 2'd3, 1'b0, 32'h40, 32'h1234_5678);
    wait_rvalid(lat);
    check("lat_illegal", lat, 32'd1);

    force_stall = 1'b1;
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'hCAFE_F00D);
    wait_rvalid(lat);
    force_stall = 1'b0;
    zero_wait   = 1'b0;

    // Reset while waiting for the first read response
    resp_block = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    guard = 0;
    while (!resp_pend && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    if (!resp_pend) fail_now("reset_test_no_grant");
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("midrst_data_req", {31'b0, data_req_o}, 32'd0);
    check("midrst_core_rvalid", {31'b0, core_rvalid_o}, 32'd0);
    exp_resp.delete();
    exp_acc.delete();
    resp_block = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("postrst_no_rvalid", {31'b0, core_rvalid_o}, 32'd0);
    end

    // Randomized traffic, issued back to back
    for (int i = 0; i < 300; i++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                       : 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
    end

    guard = 0;
    while (exp_resp.size() != 0 && guard < 2000) begin
      @(negedge clk_i);
      guard++;
    end
    if (exp_resp.size() != 0) fail_now("drain_timeout");
    repeat (3) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
